sram_retention_ctrl: RTL and testbench

Per-bank retention controller placed between the bus-side memory requesters and the `sram_wrapper` banks. It monitors traffic to each bank and drives the bank's `set_retentive_ni` input low after a programmable number of consecutive idle cycles. On a new request to a retentive bank it wakes the bank, gating the grant for a fixed wake-up time. Software can force retention per bank and enable or disable automatic retention globally.

---
 rtl/sram_ret_pkg.sv | 19 +
 rtl/sram_ret_bank_fsm.sv | 91 +++++++++
 rtl/sram_retention_ctrl.sv | 38 +++
 tb/tb_sram_retention_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/sram_ret_pkg.sv
// Shared types for the per-bank SRAM retention controller.
// Holds the bank FSM state encoding and the counter-width helper.
package sram_ret_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        RET    = 2'd1,
        WAKE   = 2'd2
    } sram_ret_state_e;

    // One counter serves both the idle count and the wake countdown, so it must hold the larger span.
    function automatic int unsigned ret_cnt_width(input int unsigned idle_cycles,
                                                  input int unsigned wake_cycles);
        int unsigned span;
        span = (idle_cycles > wake_cycles) ? idle_cycles : wake_cycles;
        return $clog2(span + 1);
    endfunction

endpackage

// File: rtl/sram_ret_bank_fsm.sv
// Retention FSM for a single SRAM bank: ACTIVE -> RET on idle/force, RET -> WAKE -> ACTIVE on demand.
// The shared counter tracks idle cycles in ACTIVE and the remaining wake time in WAKE.
module sram_ret_bank_fsm
    import sram_ret_pkg::*;
#(
    parameter int unsigned IdleCycles = 64,
    parameter int unsigned WakeCycles = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ret_en_i,
    input  logic force_ret_i,
    input  logic bank_req_i,
    output logic bank_gnt_o,
    output logic mem_req_o,
    output logic set_retentive_no,
    output logic bank_ret_o
);

    localparam int unsigned    CntW    = ret_cnt_width(IdleCycles, WakeCycles);
    localparam logic [CntW-1:0] IdleMax = CntW'(IdleCycles - 1);
    localparam logic [CntW-1:0] WakeMax = CntW'(WakeCycles - 1);

    sram_ret_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACTIVE: begin
                if (bank_req_i) begin
                    cnt_d = '0;
                end else if (force_ret_i || (ret_en_i && (cnt_q == IdleMax))) begin
                    state_d = RET;
                    cnt_d   = '0;
                end else if (cnt_q != IdleMax) begin
                    // Saturate so a later ret_en_i rise enters retention immediately.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RET: begin
                if (!force_ret_i && (bank_req_i || !ret_en_i)) begin
                    state_d = WAKE;
                    cnt_d   = WakeMax;
                end
            end
            WAKE: begin
                if (cnt_q == '0) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = ACTIVE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        bank_gnt_o       = 1'b0;
        mem_req_o        = 1'b0;
        set_retentive_no = 1'b1;
        bank_ret_o       = 1'b0;
        case (state_q)
            ACTIVE: begin
                bank_gnt_o = bank_req_i;
                mem_req_o  = bank_req_i;
            end
            RET: begin
                set_retentive_no = 1'b0;
                bank_ret_o       = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sram_retention_ctrl.sv
// Per-bank retention controller sitting between bus requesters and the sram_wrapper banks.
// Each bank runs an independent FSM; only ret_en_i is common to all of them.
module sram_retention_ctrl
    import sram_ret_pkg::*;
#(
    parameter int unsigned NumBanks   = 2,
    parameter int unsigned IdleCycles = 64,
    parameter int unsigned WakeCycles = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                ret_en_i,
    input  logic [NumBanks-1:0] force_ret_i,
    input  logic [NumBanks-1:0] bank_req_i,
    output logic [NumBanks-1:0] bank_gnt_o,
    output logic [NumBanks-1:0] mem_req_o,
    output logic [NumBanks-1:0] set_retentive_no,
    output logic [NumBanks-1:0] bank_ret_o
);

    for (genvar b = 0; b < NumBanks; b++) begin : g_bank
        sram_ret_bank_fsm #(
            .IdleCycles(IdleCycles),
            .WakeCycles(WakeCycles)
        ) u_fsm (
            .clk_i           (clk_i),
            .rst_ni          (rst_ni),
            .ret_en_i        (ret_en_i),
            .force_ret_i     (force_ret_i[b]),
            .bank_req_i      (bank_req_i[b]),
            .bank_gnt_o      (bank_gnt_o[b]),
            .mem_req_o       (mem_req_o[b]),
            .set_retentive_no(set_retentive_no[b]),
            .bank_ret_o      (bank_ret_o[b])
        );
    end

endmodule

// File: tb/tb_sram_retention_ctrl.sv
// Scoreboard bench for sram_retention_ctrl with IdleCycles=8, WakeCycles=3, two banks.
// Stimulus pushes hand-computed per-cycle expectations; a negedge monitor pops and compares.
module tb_sram_retention_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ret_en_i = 1'b1;
    logic [1:0] force_ret_i = 2'b00;
    logic [1:0] bank_req_i = 2'b00;
    logic [1:0] bank_gnt_o, mem_req_o, set_retentive_no, bank_ret_o;

    sram_retention_ctrl #(
        .NumBanks  (2),
        .IdleCycles(8),
        .WakeCycles(3)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .ret_en_i        (ret_en_i),
        .force_ret_i     (force_ret_i),
        .bank_req_i      (bank_req_i),
        .bank_gnt_o      (bank_gnt_o),
        .mem_req_o       (mem_req_o),
        .set_retentive_no(set_retentive_no),
        .bank_ret_o      (bank_ret_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] setn;
        logic [1:0] ret;
        logic [1:0] gnt;
        string      tag;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_n  = 0;

    task automatic check(input string name, input exp_t e, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s.%s cycle %0d: got %b expected %b", e.tag, name, e.cyc, got, want);
        end
    endtask

    // Drive one cycle's inputs just after the edge and queue the outputs expected in that cycle.
    task automatic step(input logic rn, input logic en, input logic [1:0] rq, input logic [1:0] fr,
                        input logic [1:0] xs, input logic [1:0] xr, input logic [1:0] xg,
                        input string tag);
        exp_t e;
        @(posedge clk_i);
        #1;
        rst_ni      = rn;
        ret_en_i    = en;
        bank_req_i  = rq;
        force_ret_i = fr;
        e.setn = xs;
        e.ret  = xr;
        e.gnt  = xg;
        e.tag  = tag;
        e.cyc  = cyc_n;
        q.push_back(e);
        cyc_n++;
    endtask

    task automatic rep(input int n, input logic rn, input logic en, input logic [1:0] rq,
                       input logic [1:0] fr, input logic [1:0] xs, input logic [1:0] xr,
                       input logic [1:0] xg, input string tag);
        for (int i = 0; i < n; i++) step(rn, en, rq, fr, xs, xr, xg, tag);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("set_retentive_no", e, set_retentive_no, e.setn);
                check("bank_ret_o", e, bank_ret_o, e.ret);
                check("bank_gnt_o", e, bank_gnt_o, e.gnt);
                check("mem_req_o", e, mem_req_o, e.gnt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        // Reset with arbitrary requests: all banks ACTIVE, grant follows request.
        for (int i = 0; i < 2; i++) begin
            r = 2'($urandom_range(0, 3));
            step(1'b0, 1'b1, r, 2'b00, 2'b11, 2'b00, r, "reset");
        end
        cyc_n = 0;
        // Bank 0 idle from cycle 1 enters RET at cycle 9; bank 1 keeps requesting.
        step(1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, "idle");
        rep(8, 1'b1, 1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, "idle");
        rep(4, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10, "idle");
        // Request seen in RET at 13: WAKE 14..16, grant at 17.
        step(1'b1, 1'b1, 2'b11, 2'b00, 2'b10, 2'b01, 2'b10, "wake");
        rep(3, 1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b10, "wake");
        rep(2, 1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, "wake");
        // Request exactly at idle count 7 (cycle 26) restarts the count; RET at 35.
        rep(7, 1'b1, 1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, "thresh");
        step(1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, "thresh");
        rep(8, 1'b1, 1'b1, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, "thresh");
        rep(2, 1'b1, 1'b1, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10, "thresh");
        // Dropping ret_en_i in RET wakes the bank without a request.
        step(1'b1, 1'b0, 2'b10, 2'b00, 2'b10, 2'b01, 2'b10, "enoff");
        rep(3, 1'b1, 1'b0, 2'b10, 2'b00, 2'b11, 2'b00, 2'b10, "enoff");
        rep(100, 1'b1, 1'b0, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "enoff_idle");
        // Counters saturated at 7: re-enabling retention enters RET on the next edge.
        step(1'b1, 1'b1, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00, "saturate");
        step(1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b11, 2'b00, "saturate");
        // Both banks wake simultaneously.
        step(1'b1, 1'b1, 2'b11, 2'b00, 2'b00, 2'b11, 2'b00, "bothwake");
        rep(3, 1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, "bothwake");
        step(1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, "bothwake");
        // Force bank 1 while idle, then hold a request against the force for 20 cycles.
        step(1'b1, 1'b1, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01, "force");
        rep(20, 1'b1, 1'b1, 2'b11, 2'b10, 2'b01, 2'b10, 2'b01, "force");
        // Release at c=169: WAKE 170..172, grant at 173.
        step(1'b1, 1'b1, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01, "release");
        rep(3, 1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b01, "release");
        step(1'b1, 1'b1, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, "release");
        // Force with a request present does not pull an ACTIVE bank into RET.
        rep(2, 1'b1, 1'b1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b11, "force_busy");
        // Reset asserted during WAKE returns to ACTIVE on that edge.
        step(1'b1, 1'b1, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, "rst_wake");
        step(1'b1, 1'b1, 2'b01, 2'b00, 2'b10, 2'b01, 2'b00, "rst_wake");
        step(1'b0, 1'b1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, "rst_wake");
        rep(2, 1'b1, 1'b1, 2'b01, 2'b00, 2'b11, 2'b00, 2'b01, "rst_wake");

        repeat (2) @(negedge clk_i);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
